// File: rtl/decode_bundle_packer.sv
// rtl/decode_bundle_packer.sv - compacts decoded micro-ops of a fetch bundle into contiguous low slots
// Optional second micro-op per instruction enabled by `define DECODE_DUAL_UOP_EN.
module decode_bundle_packer #(
    parameter int FETCH_WIDTH = 4,
    parameter int PKT_W       = 64,
    parameter int CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [FETCH_WIDTH-1:0]             in_mask_i,
    input  logic [FETCH_WIDTH-1:0]             in_dual_i,
    input  logic [2*FETCH_WIDTH*PKT_W-1:0]     in_pkt_i,
    input  logic                               stall_i,
    output logic                               decodeReady_o,
    output logic [2*FETCH_WIDTH-1:0]           decodedVector_o,
    output logic [2*FETCH_WIDTH*PKT_W-1:0]     decodedPacket_o,
    output logic [$clog2(2*FETCH_WIDTH):0]     uopCount_o,
    output logic [CNT_W-1:0]                   stallCycles_o
);

    localparam int SLOTS = 2 * FETCH_WIDTH;
    localparam int CW    = $clog2(SLOTS) + 1;
`ifdef DECODE_DUAL_UOP_EN
    localparam int SRC_N = SLOTS;
`else
    localparam int SRC_N = FETCH_WIDTH;
`endif

    logic [SRC_N-1:0]       src_valid;
    logic [PKT_W-1:0]       src_pkt [SRC_N];
    logic [SLOTS*PKT_W-1:0] cmp_pkt;
    logic [SLOTS-1:0]       cmp_vec;
    logic [CW-1:0]          cmp_cnt;

    logic                   ready_q;
    logic [SLOTS-1:0]       vec_q;
    logic [SLOTS*PKT_W-1:0] pkt_q;
    logic [CW-1:0]          cnt_q;
    logic [CNT_W-1:0]       stall_q;
    logic                   accept;

    // Without dual uops only even source slots exist; odd packets and dual bits are dropped.
    wire unused_inputs = ^{in_dual_i, in_pkt_i};

    for (genvar s = 0; s < SRC_N; s++) begin : g_src
`ifdef DECODE_DUAL_UOP_EN
        assign src_valid[s] = in_mask_i[s/2] & ((s % 2 == 0) | in_dual_i[s/2]);
        assign src_pkt[s]   = in_pkt_i[s*PKT_W +: PKT_W];
`else
        assign src_valid[s] = in_mask_i[s];
        assign src_pkt[s]   = in_pkt_i[2*s*PKT_W +: PKT_W];
`endif
    end

    // The n-th valid source lands in output slot n, preserving program order.
    always_comb begin
        cmp_pkt = '0;
        cmp_cnt = '0;
        for (int s = 0; s < SRC_N; s++) begin
            if (src_valid[s]) begin
                cmp_pkt[cmp_cnt*PKT_W +: PKT_W] = src_pkt[s];
                cmp_cnt = cmp_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        cmp_vec = '0;
        for (int j = 0; j < SLOTS; j++) begin
            cmp_vec[j] = (j < SRC_N) && (CW'(j) < cmp_cnt);
        end
    end

    assign in_ready_o = ~ready_q | ~stall_i;
    assign accept     = in_valid_i & in_ready_o & ~flush_i;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            ready_q <= 1'b0;
            vec_q   <= '0;
            pkt_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            ready_q <= (cmp_cnt != '0);
            vec_q   <= cmp_vec;
            pkt_q   <= cmp_pkt;
            cnt_q   <= cmp_cnt;
        end else if (ready_q && !stall_i) begin
            ready_q <= 1'b0;
            vec_q   <= '0;
            cnt_q   <= '0;
        end
    end

    // Flush leaves the counter alone so stall statistics survive mispredicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (ready_q && stall_i && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign decodeReady_o   = ready_q;
    assign decodedVector_o = vec_q;
    assign decodedPacket_o = pkt_q;
    assign uopCount_o      = cnt_q;
    assign stallCycles_o   = stall_q;

endmodule
